dec_stage_pipe: RTL and testbench
=================================

# dec_stage_pipe

Parametrised, pipelined instruction-decode stage: owns the register file, write-back data select, operand-B address select and immediate extension, and registers its results into a decode/execute pipeline register with a valid/ready handshake. It sits between the fetch stage (Instr source) and the execute stage (operand consumer), and takes write-back from the ALU/MEM stages. New relative to the unpipelined decode stage:

- parametrised width and depth;
- same-cycle write-to-read bypass;
- stall handling;
- in-place refresh of held operands on write-back.

## Interface
- DATA_W, 32, register and operand width (≥16)
- NREGS, 32, register count (power of two, ≥2); AW = $clog2(NREGS), ≤5
- R0_ZERO, 1, register 0 reads as zero and ignores writes
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Instr  in  32  instruction: opcode [31:26], rs [25:21], rd [20:16], rt [15:11], imm [15:0]
- In_valid  in  1  Instr valid
- In_ready  out  1  stage accepts Instr this cycle
- RF_B_sel  in  1  0: read port B uses rt; 1: uses rd
- RF_WrEn  in  1  write-back enable
- RF_WrAddr  in  AW  write-back register
- RF_WrData_sel  in  1  0: ALU_out; 1: MEM_out
- ALU_out, MEM_out  in  DATA_W  write-back candidates
- Out_valid  out  1  output register holds a decoded instruction
- Out_ready  in  1  execute stage consumes output
- RF_A, RF_B, Immed  out  DATA_W  registered operands and extended immediate
- Rd_q  out  AW  registered rd field; Opcode_q  out  6  registered opcode

## Operation
- Write data: WrData = RF_WrData_sel ? MEM_out : ALU_out. Written at the clock edge when RF_WrEn, except register 0 when R0_ZERO.
- Reads are combinational from Instr fields truncated to AW bits. Read address A = rs; B = RF_B_sel ? rd : rt.
- Bypass: if RF_WrEn and RF_WrAddr equals a read address (and it is not register 0 with R0_ZERO), the read returns WrData, not the stale entry.
- Immediate extension by opcode (constants live in the package):
  - LUI 111001: imm << 16
  - ANDI 110010, ORI 110011: zero-extend
  - B 111111, BEQ 000000, BNE 000001: sign-extend then << 2
  - all other opcodes: sign-extend
  - results are truncated/extended to DATA_W
- Handshake: In_ready = !Out_valid | Out_ready. On In_valid & In_ready, the output register loads the operands, Immed, Rd_q and Opcode_q, and sets Out_valid. On Out_ready & Out_valid with no new load, Out_valid clears.
- Held refresh: while Out_valid & !Out_ready, a write-back to the register that supplied RF_A (or RF_B) overwrites the held RF_A (or RF_B) with WrData. Source addresses are stored internally for this comparison; register 0 is never refreshed when R0_ZERO.

## Timing
- Reset state: Out_valid=0, RF_A=RF_B=Immed=0, Rd_q=0, Opcode_q=0, all registers=0. In_ready=1 after reset.
- Decode latency: 1 cycle from accept to Out_valid.
- Full throughput: 1 instruction per cycle while Out_ready=1.
- Write-back visible to a read in the same cycle through the bypass; the array itself updates at the edge.
- Simultaneous accept and write to a source register: the loaded operand equals WrData.
- Simultaneous consume, accept and write: new contents load; no refresh of the departing ones.
- Reset asserted mid-stall: output and array clear immediately; the in-flight instruction is lost.
- Out_valid and data change only at clock edges; they remain stable while Out_ready=0, except for the held refresh.

## Structure
- Package dec_pkg: opcode localparams (LUI, ANDI, ORI, B, BEQ, BNE), imm_mode enum (SEXT, ZEXT, HI16, SEXT_SH2), and an opcode-to-imm_mode function.
- Sub-module regfile_bypass (parameters DATA_W, NREGS, R0_ZERO): array, two read ports, one write port, bypass logic.
- Top level holds the data mux, address mux, immediate unit, pipeline register and refresh comparators.

## Test plan
- Reset, then write 0x0000_00AA to r3 with ALU select; the next instruction with rs=3 -> RF_A=0x0000_00AA one cycle after accept.
- Instr with rs=5, written 0x1234 via MEM_out in the same cycle -> RF_A=0x1234 (bypass).
- Write 0xFFFF to r0 (R0_ZERO=1) -> a read of r0 gives 0.
- Immediates for imm=0x8001: ORI -> 0x0000_8001; ADDI-class -> 0xFFFF_8001; LUI -> 0x8001_0000; BEQ -> 0xFFFE_0004.
- Hold Out_ready=0 with RF_B sourced from r7, then write r7=0x55 -> In_ready=0 and RF_B becomes 0x55. Release -> one handoff, then the next instruction loads.
- DATA_W=16, NREGS=8: address bits above [2:0] ignored; the LUI result truncates to 0x0000. Assert Rst_n low mid-stall -> Out_valid=0 asynchronously.

Source files
------------

// File: rtl/dec_stage_pipe_pkg.sv
// Shared decode definitions: opcodes with special immediate handling and the
// opcode-to-extension-mode mapping used by the decode stage.
package dec_pkg;

    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;

    typedef enum logic [1:0] {
        IMM_SEXT     = 2'd0,
        IMM_ZEXT     = 2'd1,
        IMM_HI16     = 2'd2,
        IMM_SEXT_SH2 = 2'd3
    } imm_mode_e;

    function automatic imm_mode_e imm_mode_of(input logic [5:0] op);
        imm_mode_e mode;
        case (op)
            OP_LUI:                mode = IMM_HI16;
            OP_ANDI, OP_ORI:       mode = IMM_ZEXT;
            OP_B, OP_BEQ, OP_BNE:  mode = IMM_SEXT_SH2;
            default:               mode = IMM_SEXT;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/dec_stage_pipe_if.sv
// Decode-stage bundle: fetch handshake, write-back port and execute handshake.
// master = surrounding pipeline, slave = decode stage.
interface dec_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    logic [31:0]       instr;
    logic              in_valid;
    logic              in_ready;
    logic              rf_b_sel;
    logic              rf_wr_en;
    logic [AW-1:0]     rf_wr_addr;
    logic              rf_wr_data_sel;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mem_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] immed;
    logic [AW-1:0]     rd_q;
    logic [5:0]        opcode_q;

    modport master (
        output instr, in_valid, rf_b_sel, rf_wr_en, rf_wr_addr, rf_wr_data_sel,
               alu_out, mem_out, out_ready,
        input  in_ready, out_valid, rf_a, rf_b, immed, rd_q, opcode_q
    );

    modport slave (
        input  instr, in_valid, rf_b_sel, rf_wr_en, rf_wr_addr, rf_wr_data_sel,
               alu_out, mem_out, out_ready,
        output in_ready, out_valid, rf_a, rf_b, immed, rd_q, opcode_q
    );
endinterface

// File: rtl/dec_stage_pipe_regfile.sv
// Register file with one write port and two combinational read ports. A read
// that hits the register being written this cycle returns the incoming data.
module regfile_bypass #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1'b1,
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_a_i,
    input  logic [AW-1:0]     rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o
);
    logic [DATA_W-1:0] mem_q [NREGS];
    logic              wr_ok;
    logic              zero_a, zero_b;

    assign wr_ok  = wr_en_i & ~(R0_ZERO && (wr_addr_i == '0));
    assign zero_a = R0_ZERO && (rd_addr_a_i == '0);
    assign zero_b = R0_ZERO && (rd_addr_b_i == '0);

    // Array update; reset clears every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = zero_a ? '0 :
                         (wr_ok && (wr_addr_i == rd_addr_a_i)) ? wr_data_i : mem_q[rd_addr_a_i];
    assign rd_data_b_o = zero_b ? '0 :
                         (wr_ok && (wr_addr_i == rd_addr_b_i)) ? wr_data_i : mem_q[rd_addr_b_i];
endmodule

// File: rtl/dec_stage_pipe.sv
// Pipelined decode stage: operand fetch with bypass, immediate extension and a
// valid/ready decode/execute register whose held operands track write-back.
module dec_stage_pipe
    import dec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    dec_stage_pipe_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [4:0]        rs_f, rd_f, rt_f;
    logic [AW-1:0]     addr_a, addr_b, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_a, rd_b;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0] imm_sext, imm_zext, imm_ext;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [AW-1:0]     rd_q, rd_d, src_a_q, src_a_d, src_b_q, src_b_d;
    logic [5:0]        op_q, op_d;
    logic              ready, load, hold, refresh_a, refresh_b;

    assign rs_f    = bus.instr[25:21];
    assign rd_f    = bus.instr[20:16];
    assign rt_f    = bus.instr[15:11];
    assign addr_a  = rs_f[AW-1:0];
    assign rd_addr = rd_f[AW-1:0];
    assign addr_b  = bus.rf_b_sel ? rd_addr : rt_f[AW-1:0];
    assign wr_data = bus.rf_wr_data_sel ? bus.mem_out : bus.alu_out;

    regfile_bypass #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .R0_ZERO (R0_ZERO)
    ) u_rf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (bus.rf_wr_en),
        .wr_addr_i   (bus.rf_wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (addr_a),
        .rd_addr_b_i (addr_b),
        .rd_data_a_o (rd_a),
        .rd_data_b_o (rd_b)
    );

    // Size casts do the sign/zero extension or truncation to DATA_W.
    assign imm_s    = signed'(bus.instr[15:0]);
    assign imm_sext = DATA_W'(imm_s);
    assign imm_zext = DATA_W'(bus.instr[15:0]);

    // Immediate extension selected by opcode class.
    always_comb begin
        imm_ext = imm_sext;
        case (imm_mode_of(bus.instr[31:26]))
            IMM_ZEXT:     imm_ext = imm_zext;
            IMM_HI16:     imm_ext = imm_zext << 16;
            IMM_SEXT_SH2: imm_ext = imm_sext << 2;
            default:      imm_ext = imm_sext;
        endcase
    end

    assign ready = ~valid_q | bus.out_ready;
    assign load  = bus.in_valid & ready;
    assign hold  = valid_q & ~bus.out_ready;
    // A held operand follows write-back to its source register; r0 is constant.
    assign refresh_a = hold & bus.rf_wr_en & (bus.rf_wr_addr == src_a_q)
                       & ~(R0_ZERO && (src_a_q == '0));
    assign refresh_b = hold & bus.rf_wr_en & (bus.rf_wr_addr == src_b_q)
                       & ~(R0_ZERO && (src_b_q == '0));

    // Next state of the decode/execute register.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        if (load) begin
            valid_d = 1'b1;
            a_d     = rd_a;
            b_d     = rd_b;
            imm_d   = imm_ext;
            rd_d    = rd_addr;
            op_d    = bus.instr[31:26];
            src_a_d = addr_a;
            src_b_d = addr_b;
        end else begin
            if (refresh_a) a_d = wr_data;
            if (refresh_b) b_d = wr_data;
            if (bus.out_ready) valid_d = 1'b0;
        end
    end

    // Decode/execute register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.rf_a      = a_q;
    assign bus.rf_b      = b_q;
    assign bus.immed     = imm_q;
    assign bus.rd_q      = rd_q;
    assign bus.opcode_q  = op_q;
endmodule

// File: tb/tb_dec_stage_pipe.sv
// Bench for dec_stage_pipe: a 32x32 and a 16-bit/8-register instance share one
// stimulus stream and are compared against a behavioural model every cycle.
module tb_dec_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid, out_ready, b_sel, wr_en, wd_sel;
    logic [4:0]  wa;
    logic [31:0] alu, mem;

    always #5 clk = ~clk;

    dec_stage_pipe_if #(.DATA_W(32), .AW(5)) if0 ();
    dec_stage_pipe_if #(.DATA_W(16), .AW(3)) if1 ();

    assign if0.instr = instr;          assign if1.instr = instr;
    assign if0.in_valid = in_valid;    assign if1.in_valid = in_valid;
    assign if0.out_ready = out_ready;  assign if1.out_ready = out_ready;
    assign if0.rf_b_sel = b_sel;       assign if1.rf_b_sel = b_sel;
    assign if0.rf_wr_en = wr_en;       assign if1.rf_wr_en = wr_en;
    assign if0.rf_wr_data_sel = wd_sel; assign if1.rf_wr_data_sel = wd_sel;
    assign if0.rf_wr_addr = wa;        assign if1.rf_wr_addr = wa[2:0];
    assign if0.alu_out = alu;          assign if1.alu_out = alu[15:0];
    assign if0.mem_out = mem;          assign if1.mem_out = mem[15:0];

    dec_stage_pipe #(.DATA_W(32), .NREGS(32), .R0_ZERO(1'b1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0));
    dec_stage_pipe #(.DATA_W(16), .NREGS(8), .R0_ZERO(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1));

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = 32-bit config, 1 = 16-bit/8-register config.
    logic [31:0] m_regs [2][32];
    logic        m_v  [2];
    logic [31:0] m_a  [2];
    logic [31:0] m_b  [2];
    logic [31:0] m_imm[2];
    logic [4:0]  m_rd [2];
    logic [4:0]  m_sa [2];
    logic [4:0]  m_sb [2];
    logic [5:0]  m_op [2];

    function automatic logic [31:0] dmask(int c);
        return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [4:0] amask(int c);
        return (c == 0) ? 5'h1F : 5'h07;
    endfunction

    function automatic logic [31:0] m_immf(logic [5:0] op, logic [15:0] imm, int c);
        longint s, v;
        s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        case (op)
            6'b111001:            v = longint'(imm) * 65536;
            6'b110010, 6'b110011: v = longint'(imm);
            6'b111111, 6'b000000, 6'b000001: v = s * 4;
            default:              v = s;
        endcase
        return v[31:0] & dmask(c);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) m_regs[c][r] = '0;
            m_v[c] = 1'b0; m_a[c] = '0; m_b[c] = '0; m_imm[c] = '0;
            m_rd[c] = '0; m_op[c] = '0; m_sa[c] = '0; m_sb[c] = '0;
        end
    endtask

    function automatic logic [31:0] m_read(int c, logic [4:0] addr, logic [31:0] wd);
        if (addr == 5'd0) return 32'h0;
        if (wr_en && ((wa & amask(c)) == addr)) return wd;
        return m_regs[c][addr];
    endfunction

    task automatic check_outputs();
        check("c0 out_valid", {31'h0, if0.out_valid}, {31'h0, m_v[0]});
        check("c0 rf_a", if0.rf_a, m_a[0]);
        check("c0 rf_b", if0.rf_b, m_b[0]);
        check("c0 immed", if0.immed, m_imm[0]);
        check("c0 rd_q", {27'h0, if0.rd_q}, {27'h0, m_rd[0]});
        check("c0 opcode_q", {26'h0, if0.opcode_q}, {26'h0, m_op[0]});
        check("c1 out_valid", {31'h0, if1.out_valid}, {31'h0, m_v[1]});
        check("c1 rf_a", {16'h0, if1.rf_a}, m_a[1]);
        check("c1 rf_b", {16'h0, if1.rf_b}, m_b[1]);
        check("c1 immed", {16'h0, if1.immed}, m_imm[1]);
        check("c1 rd_q", {27'h0, if1.rd_q}, {27'h0, m_rd[1]});
        check("c1 opcode_q", {26'h0, if1.opcode_q}, {26'h0, m_op[1]});
    endtask

    // One clock: check in_ready, advance the model, then compare after the edge.
    task automatic step();
        logic [31:0] wd;
        logic [4:0]  am, wam, ra, rdf, rtf, rb;
        logic        rdy;
        #1;
        check("c0 in_ready", {31'h0, if0.in_ready}, {31'h0, (!m_v[0] || out_ready)});
        check("c1 in_ready", {31'h0, if1.in_ready}, {31'h0, (!m_v[1] || out_ready)});
        for (int c = 0; c < 2; c++) begin
            am  = amask(c);
            wd  = (wd_sel ? mem : alu) & dmask(c);
            wam = wa & am;
            rdy = !m_v[c] || out_ready;
            ra  = instr[25:21] & am;
            rdf = instr[20:16] & am;
            rtf = instr[15:11] & am;
            rb  = b_sel ? rdf : rtf;
            if (in_valid && rdy) begin
                m_a[c]   = m_read(c, ra, wd);
                m_b[c]   = m_read(c, rb, wd);
                m_imm[c] = m_immf(instr[31:26], instr[15:0], c);
                m_rd[c]  = rdf;
                m_op[c]  = instr[31:26];
                m_sa[c]  = ra;
                m_sb[c]  = rb;
                m_v[c]   = 1'b1;
            end else begin
                if (m_v[c] && !out_ready && wr_en) begin
                    if (wam == m_sa[c] && m_sa[c] != 5'd0) m_a[c] = wd;
                    if (wam == m_sb[c] && m_sb[c] != 5'd0) m_b[c] = wd;
                end
                if (out_ready) m_v[c] = 1'b0;
            end
            if (wr_en && wam != 5'd0) m_regs[c][wam] = wd;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        instr = '0; in_valid = 1'b0; out_ready = 1'b1; b_sel = 1'b0;
        wr_en = 1'b0; wd_sel = 1'b0; wa = '0; alu = '0; mem = '0;
    endtask

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rd,
                                       logic [15:0] low);
        return {op, rs, rd, low};
    endfunction

    logic [5:0]  imm_ops [4];
    logic [31:0] imm_exp0 [4];
    logic [31:0] imm_exp1 [4];
    logic [5:0]  rand_ops [8];

    initial begin
        imm_ops  = '{6'b110011, 6'b001000, 6'b111001, 6'b000000};
        imm_exp0 = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004};
        imm_exp1 = '{32'h0000_8001, 32'h0000_8001, 32'h0000_0000, 32'h0000_0004};
        rand_ops = '{6'b111001, 6'b110010, 6'b110011, 6'b111111,
                     6'b000000, 6'b000001, 6'b001000, 6'b100011};

        // Reset state
        rst_n = 1'b0;
        set_idle();
        m_reset();
        #12;
        check_outputs();
        check("reset c0 in_ready", {31'h0, if0.in_ready}, 32'h1);
        check("reset c1 in_ready", {31'h0, if1.in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // r3 <= 0xAA via ALU, then read it through rs
        wr_en = 1'b1; wa = 5'd3; alu = 32'h0000_00AA; wd_sel = 1'b0;
        step();
        set_idle();
        instr = mk(6'b001000, 5'd3, 5'd1, 16'h0000); in_valid = 1'b1;
        step();
        check("array read rf_a", if0.rf_a, 32'h0000_00AA);

        // Same-cycle bypass via MEM_out
        set_idle();
        instr = mk(6'b001000, 5'd5, 5'd0, 16'h0000); in_valid = 1'b1;
        wr_en = 1'b1; wa = 5'd5; wd_sel = 1'b1; mem = 32'h0000_1234;
        step();
        check("bypass rf_a", if0.rf_a, 32'h0000_1234);

        // Writes to r0 are ignored
        set_idle();
        wr_en = 1'b1; wa = 5'd0; alu = 32'h0000_FFFF;
        step();
        set_idle();
        instr = mk(6'b001000, 5'd0, 5'd0, 16'h0000); in_valid = 1'b1;
        wr_en = 1'b1; wa = 5'd0; alu = 32'h0000_FFFF;
        step();
        check("r0 rf_a", if0.rf_a, 32'h0);
        check("r0 rf_b", if0.rf_b, 32'h0);

        // Immediate extension of 0x8001, back to back
        for (int i = 0; i < 4; i++) begin
            set_idle();
            instr = mk(imm_ops[i], 5'd1, 5'd2, 16'h8001); in_valid = 1'b1;
            step();
            check($sformatf("imm c0 op%0d", i), if0.immed, imm_exp0[i]);
            check($sformatf("imm c1 op%0d", i), {16'h0, if1.immed}, imm_exp1[i]);
        end

        // Stall with RF_B from r7, write-back refreshes it, then release
        set_idle();
        instr = mk(6'b001000, 5'd1, 5'd4, 16'h3800); in_valid = 1'b1;
        step();
        set_idle();
        out_ready = 1'b0;
        instr = mk(6'b001010, 5'd2, 5'd6, 16'h0000); in_valid = 1'b1;
        wr_en = 1'b1; wa = 5'd7; alu = 32'h0000_0055;
        step();
        check("stall in_ready", {31'h0, if0.in_ready}, 32'h0);
        check("refresh rf_b", if0.rf_b, 32'h0000_0055);
        check("refresh c1 rf_b", {16'h0, if1.rf_b}, 32'h0000_0055);
        wr_en = 1'b0; out_ready = 1'b1;
        step();
        check("release opcode", {26'h0, if0.opcode_q}, {26'h0, 6'b001010});
        in_valid = 1'b0;
        step();
        check("release drained", {31'h0, if0.out_valid}, 32'h0);

        // Upper address bits ignored by the 8-register instance
        set_idle();
        wr_en = 1'b1; wa = 5'b01010; alu = 32'h0000_0077;
        step();
        set_idle();
        instr = mk(6'b001000, 5'd2, 5'd10, 16'h0000); in_valid = 1'b1;
        step();
        check("c1 alias rf_a", {16'h0, if1.rf_a}, 32'h0000_0077);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 1) == 0) instr[31:26] = rand_ops[$urandom_range(0, 7)];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            b_sel     = 1'($urandom_range(0, 1));
            wr_en     = 1'($urandom_range(0, 1));
            wd_sel    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       wa = m_sa[0];
                1:       wa = m_sb[0];
                default: wa = 5'($urandom_range(0, 31));
            endcase
            alu = $urandom;
            mem = $urandom;
            step();
        end

        // Asynchronous reset in the middle of a stall
        set_idle();
        instr = mk(6'b001000, 5'd3, 5'd3, 16'h1800); in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("pre-reset valid", {31'h0, if0.out_valid}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        instr = mk(6'b001000, 5'd3, 5'd3, 16'h1800); in_valid = 1'b1;
        step();
        check("array cleared", if0.rf_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
